uart_rx_frame_parser: RTL and testbench
=======================================

# uart_rx_frame_parser

Downstream stage of the UART receiver. Consumes the receiver's byte-valid strobe and received byte, hunts for a start-of-frame byte, then collects a length-prefixed payload and a trailing checksum. Payload is buffered and released on a valid/ready byte stream only after the checksum verifies, so corrupt or truncated frames never reach downstream logic. Bad length, bad checksum, inter-byte timeout and overrun are reported as error pulses with a code.

## Interface
- MAX_LEN, 16 — largest accepted payload length in bytes (1..255); sets buffer depth.
- SOF, 8'hA5 — start-of-frame byte.
- TIMEOUT_CLKS, 104170 — idle clocks allowed between bytes inside a frame.
- i_clk  input  1  — system clock, same clock as the UART receiver.
- i_rst_n  input  1  — reset; one clock, asynchronous, active-low.
- i_dv  input  1  — receiver data-valid; a rising edge marks a new byte.
- i_rx_byte  input  8  — received byte, stable while i_dv is high.
- i_ready  input  1  — downstream accepts o_data this cycle.
- o_valid  output  1  — o_data holds a verified payload byte.
- o_data  output  8  — payload byte.
- o_last  output  1  — qualifies the final payload byte of a frame.
- o_frame_ok  output  1  — one-cycle pulse: frame passed checksum.
- o_frame_err  output  1  — one-cycle pulse: error detected.
- o_err_code  output  2  — 0 timeout, 1 bad length, 2 bad checksum, 3 overrun; held until the next error.
- o_busy  output  1  — high in every state except HUNT.

## Operation
- Byte strobe: i_dv sampled into a register each clock. Strobe = i_dv & ~i_dv_q. i_rx_byte is captured on the strobe cycle. A held-high i_dv gives exactly one strobe.
- States:
  - HUNT: strobe with byte==SOF -> LEN. Any other byte is discarded silently.
  - LEN: on strobe, byte==0 or byte>MAX_LEN -> error code 1, then HUNT. Otherwise len<=byte, sum<=byte, idx<=0, then PAYLOAD.
  - PAYLOAD: on strobe, buf[idx]<=byte, sum<=sum+byte (mod 256), idx++. When idx reaches len-1 on a strobe -> CHK.
  - CHK: on strobe, (sum+byte) mod 256 == 0 -> pulse o_frame_ok, rd_idx<=0, then DRAIN. Otherwise error code 2, then HUNT.
  - DRAIN: o_valid=1, o_data=buf[rd_idx], o_last=(rd_idx==len-1). On o_valid&i_ready, rd_idx++. Handshake with o_last -> HUNT.
- Overrun: a strobe in DRAIN drops the byte and raises error code 3. DRAIN continues. A dropped SOF is not hunted.
- Timeout: in LEN, PAYLOAD and CHK, a counter clears on every strobe and on state entry and increments otherwise. When it reaches TIMEOUT_CLKS: error code 0, then HUNT, partial payload discarded. Counter width is $clog2(TIMEOUT_CLKS+1). A strobe in the same cycle as the terminal count wins, so no timeout occurs.
- Checksum: the 8-bit sum of LEN, all payload bytes and CHK equals 0 (mod 256).

## Timing
- Reset values: o_valid, o_last, o_frame_ok, o_frame_err, o_busy = 0; o_data = 8'h00; o_err_code = 2'd0; state HUNT; buffer contents don't-care.
- All outputs are registered.
- Error and ok pulses are asserted the clock after the strobe (or terminal count) that causes them, and last exactly one cycle.
- o_valid rises the same cycle as o_frame_ok. The first byte can transfer that cycle.
- The stream delivers one byte per cycle while i_ready=1. o_data and o_last are held stable while o_valid & ~i_ready.
- Drain latency is len cycles at full throughput. HUNT resumes the cycle after the o_last handshake, and a strobe on that cycle is parsed normally.
- Reset asserted mid-frame or mid-drain: outputs clear immediately (asynchronously), and the frame is lost.

## Test plan
- Good frame: A5 03 11 22 33 97 -> o_frame_ok once; stream 11,22,33 with o_last on 33; o_busy low afterwards.
- Bad checksum: A5 03 11 22 33 96 -> o_frame_err, code 2; o_valid never asserts. The following good frame is accepted.
- Length bounds: A5 00, then A5 11 (MAX_LEN=16) -> two errors, code 1 each. A5 10 with 16 payload bytes and a correct checksum -> 16-byte stream.
- Hunt and edge detect: bytes 00 FF 5A, then A5 01 5A A5, with one i_dv held high for 3 cycles -> leading bytes ignored; a single strobe per byte; stream 5A with o_last.
- Backpressure and overrun: good 3-byte frame with i_ready=0; send byte 77 during DRAIN -> code 3 pulse; o_data=11 stays stable. Raising i_ready drains 11,22,33 intact.
- Timeout and reset: A5 02 11, then silence for TIMEOUT_CLKS -> code 0 pulse, o_busy falls. Repeat with i_rst_n pulsed low mid-payload -> all outputs 0; the next good frame is accepted.

Source files
------------

// File: rtl/uart_rx_frame_parser_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_parser_if
//
// Verified-payload byte stream leaving the UART frame parser.
//   o_valid : source holds a verified payload byte on o_data
//   o_data  : payload byte
//   o_last  : marks the final payload byte of a frame
//   i_ready : sink accepts o_data in this cycle
// Signal names keep the parser's point of view (o_ = driven by the parser).
// The master modport is the parser side; the slave modport is the consumer.
// ---------------------------------------------------------------------------
interface uart_rx_frame_parser_if;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_last;
  logic       i_ready;

  modport master (
    output o_valid,
    output o_data,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_valid,
    input  o_data,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_parser
//
// Sits behind a UART receiver. It hunts for a start-of-frame byte, then
// collects a length byte, a length-prefixed payload and a checksum byte. The
// payload is buffered and only released on the output stream once the
// checksum is verified, so corrupt or truncated frames never leave the block.
//
// Frame:  SOF | LEN (1..MAX_LEN) | LEN payload bytes | CHK
// Check:  LEN + payload bytes + CHK == 0 (mod 256)
//
// Ports
//   i_clk       : system clock (same clock as the UART receiver)
//   i_rst_n     : asynchronous active-low reset
//   i_dv        : receiver data-valid; each rising edge is one new byte
//   i_rx_byte   : received byte, stable while i_dv is high
//   stream      : verified payload stream (o_valid/o_data/o_last/i_ready)
//   o_frame_ok  : one-cycle pulse, frame passed its checksum
//   o_frame_err : one-cycle pulse, error detected
//   o_err_code  : 0 timeout, 1 bad length, 2 bad checksum, 3 overrun;
//                 held until the next error
//   o_busy      : high whenever the parser is not hunting for SOF
// ---------------------------------------------------------------------------
module uart_rx_frame_parser #(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SOF          = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 104170
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_dv,
  input  logic [7:0]                    i_rx_byte,
  uart_rx_frame_parser_if.master        stream,
  output logic                          o_frame_ok,
  output logic                          o_frame_err,
  output logic [1:0]                    o_err_code,
  output logic                          o_busy
);

  localparam int unsigned    AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned    CW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0]  TO_LIMIT  = CW'(TIMEOUT_CLKS);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
  localparam logic [1:0] ERR_LENGTH   = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic            dv_q, dv_d;
  logic            strobe;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      rd_idx_q, rd_idx_d;
  logic [7:0]      rd_idx_next;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic            timed_out;

  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            busy_q, busy_d;

  // Payload buffer; contents are don't-care after reset.
  logic [7:0]      buf_mem [MAX_LEN];
  logic            buf_we;

  // One strobe per rising edge of i_dv, however long it is held.
  assign strobe = i_dv & ~dv_q;

  // A strobe arriving on the terminal-count cycle keeps the frame alive.
  assign timed_out = (to_cnt_q == TO_LIMIT) && !strobe;

  assign rd_idx_next = rd_idx_q + 8'd1;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dv_d     = i_dv;
    len_d    = len_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    rd_idx_d = rd_idx_q;
    // Counter is zero unless a framing state explicitly advances it, which
    // covers both "clear on strobe" and "clear on state entry".
    to_cnt_d = '0;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    buf_we   = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (strobe && (i_rx_byte == SOF)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (strobe) begin
          if ((i_rx_byte == 8'd0) || (i_rx_byte > MAX_LEN_B)) begin
            err_d   = 1'b1;
            code_d  = ERR_LENGTH;
            state_d = ST_HUNT;
          end else begin
            len_d   = i_rx_byte;
            sum_d   = i_rx_byte;
            idx_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_HUNT;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end

      ST_PAYLOAD: begin
        if (strobe) begin
          buf_we = 1'b1;
          sum_d  = sum_q + i_rx_byte;
          idx_d  = idx_q + 8'd1;
          if (idx_q == (len_q - 8'd1)) begin
            state_d = ST_CHK;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_HUNT;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end

      ST_CHK: begin
        if (strobe) begin
          if ((sum_q + i_rx_byte) == 8'h00) begin
            // First byte is presented together with the ok pulse.
            ok_d     = 1'b1;
            valid_d  = 1'b1;
            rd_idx_d = 8'd0;
            data_d   = buf_mem[0];
            last_d   = (len_q == 8'd1);
            state_d  = ST_DRAIN;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHECKSUM;
            state_d = ST_HUNT;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_HUNT;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end

      ST_DRAIN: begin
        // Bytes arriving while draining are dropped, SOF included.
        if (strobe) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (valid_q && stream.i_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = 8'h00;
            state_d = ST_HUNT;
          end else begin
            rd_idx_d = rd_idx_next;
            data_d   = buf_mem[rd_idx_next[AW-1:0]];
            last_d   = (rd_idx_next == (len_q - 8'd1));
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    busy_d = (state_d != ST_HUNT);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_HUNT;
      dv_q     <= 1'b0;
      len_q    <= 8'd0;
      sum_q    <= 8'd0;
      idx_q    <= 8'd0;
      rd_idx_q <= 8'd0;
      to_cnt_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      last_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dv_q     <= dv_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      rd_idx_q <= rd_idx_d;
      to_cnt_q <= to_cnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
    end
  end

  // Buffer write port; no reset so it maps onto memory resources.
  always_ff @(posedge i_clk) begin
    if (buf_we) begin
      buf_mem[idx_q[AW-1:0]] <= i_rx_byte;
    end
  end

  assign stream.o_valid = valid_q;
  assign stream.o_data  = data_q;
  assign stream.o_last  = last_q;
  assign o_frame_ok     = ok_q;
  assign o_frame_err    = err_q;
  assign o_err_code     = code_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
module tb_uart_rx_frame_parser;

  localparam int unsigned TO_CLKS = 50;

  logic       clk;
  logic       rst_n;
  logic       dv;
  logic [7:0] rx_byte;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_rx_frame_parser_if sif ();

  uart_rx_frame_parser #(
    .MAX_LEN      (16),
    .SOF          (8'hA5),
    .TIMEOUT_CLKS (TO_CLKS)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_dv        (dv),
    .i_rx_byte   (rx_byte),
    .stream      (sif),
    .o_frame_ok  (frame_ok),
    .o_frame_err (frame_err),
    .o_err_code  (err_code),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  logic [7:0] rx_data_q [$];
  logic       rx_last_q [$];
  int         ok_cnt;
  int         err_cnt;
  logic [1:0] last_code;
  int         valid_cycles;
  logic       hold_prev;
  logic [7:0] prev_data;
  logic       prev_last;

  initial begin
    ok_cnt = 0; err_cnt = 0; last_code = 2'd0; valid_cycles = 0; hold_prev = 1'b0;
    prev_data = 8'h00; prev_last = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && sif.o_valid) begin
        check_eq("hold_data", {24'd0, sif.o_data}, {24'd0, prev_data});
        check_eq("hold_last", {31'd0, sif.o_last}, {31'd0, prev_last});
      end
      if (sif.o_valid) valid_cycles++;
      if (sif.o_valid && sif.i_ready) begin
        rx_data_q.push_back(sif.o_data);
        rx_last_q.push_back(sif.o_last);
      end
      if (frame_ok) ok_cnt++;
      if (frame_err) begin
        err_cnt++;
        last_code = err_code;
      end
      hold_prev = sif.o_valid && !sif.i_ready;
      prev_data = sif.o_data;
      prev_last = sif.o_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] tx_q  [$];
  logic [7:0] exp_q [$];

  task automatic clear_log();
    rx_data_q.delete();
    rx_last_q.delete();
    ok_cnt = 0; err_cnt = 0; valid_cycles = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    dv = 1'b1;
    rx_byte = b;
    cycles(hold);
    dv = 1'b0;
    cycles(2);
  endtask

  task automatic send_tx();
    foreach (tx_q[i]) send_byte(tx_q[i], 1);
  endtask

  task automatic check_stream(input string tag, input int budget);
    int c = 0;
    int n = exp_q.size();
    while (rx_data_q.size() < n && c < budget) begin
      cycles(1);
      c++;
    end
    cycles(2);
    check_eq({tag, "_len"}, rx_data_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_data_q.size()) begin
        check_eq({tag, "_data"}, {24'd0, rx_data_q[i]}, {24'd0, exp_q[i]});
        check_eq({tag, "_last"}, {31'd0, rx_last_q[i]}, (i == n - 1) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic wait_err(input string tag, input int budget);
    int c = 0;
    while (err_cnt == 0 && c < budget) begin
      cycles(1);
      c++;
    end
    check_eq({tag, "_err_seen"}, err_cnt, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, {31'd0, sif.o_valid}, 0);
    check_eq({tag, "_data"},  {24'd0, sif.o_data}, 0);
    check_eq({tag, "_last"},  {31'd0, sif.o_last}, 0);
    check_eq({tag, "_ok"},    {31'd0, frame_ok}, 0);
    check_eq({tag, "_err"},   {31'd0, frame_err}, 0);
    check_eq({tag, "_code"},  {30'd0, err_code}, 0);
    check_eq({tag, "_busy"},  {31'd0, busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0; dv = 1'b0; rx_byte = 8'h00; sif.i_ready = 1'b1;
    cycles(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    cycles(2);

    // 1. good frame
    clear_log();
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    exp_q = '{8'h11, 8'h22, 8'h33};
    send_tx();
    check_stream("good", 40);
    check_eq("good_ok_cnt", ok_cnt, 1);
    check_eq("good_err_cnt", err_cnt, 0);
    check_eq("good_busy_after", {31'd0, busy}, 0);
    $display("txn good_frame: ok=%0d bytes=%0d", ok_cnt, rx_data_q.size());

    // 2. bad checksum, then good frame
    clear_log();
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96};
    send_tx();
    cycles(4);
    check_eq("badchk_err_cnt", err_cnt, 1);
    check_eq("badchk_code", {30'd0, last_code}, 2);
    check_eq("badchk_no_valid", valid_cycles, 0);
    check_eq("badchk_no_ok", ok_cnt, 0);
    check_eq("badchk_busy", {31'd0, busy}, 0);
    $display("txn bad_checksum: errs=%0d code=%0d", err_cnt, last_code);
    clear_log();
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_tx();
    check_stream("after_bad", 40);
    check_eq("after_bad_ok_cnt", ok_cnt, 1);
    $display("txn good_after_bad: ok=%0d", ok_cnt);

    // 3. length bounds
    clear_log();
    tx_q = '{8'hA5, 8'h00};
    send_tx();
    cycles(2);
    check_eq("len0_err_cnt", err_cnt, 1);
    check_eq("len0_code", {30'd0, last_code}, 1);
    tx_q = '{8'hA5, 8'h11};
    send_tx();
    cycles(2);
    check_eq("len17_err_cnt", err_cnt, 2);
    check_eq("len17_code", {30'd0, last_code}, 1);
    check_eq("len_bad_busy", {31'd0, busy}, 0);
    $display("txn length_bounds: errs=%0d", err_cnt);
    clear_log();
    tx_q = '{8'hA5, 8'h10};
    exp_q.delete();
    for (int i = 1; i <= 16; i++) begin
      tx_q.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    tx_q.push_back(8'h68);  // 0x10 + (1..16 = 0x88) = 0x98; 0x100 - 0x98 = 0x68
    send_tx();
    check_stream("len16", 60);
    check_eq("len16_ok_cnt", ok_cnt, 1);
    check_eq("len16_err_cnt", err_cnt, 0);
    $display("txn max_length: bytes=%0d", rx_data_q.size());

    // 4. hunt and edge detect (5A held for three cycles)
    clear_log();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 1);
    check_eq("hunt_busy_idle", {31'd0, busy}, 0);
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h5A, 3);
    send_byte(8'hA5, 1);    // 0x01 + 0x5A = 0x5B; checksum 0xA5
    exp_q = '{8'h5A};
    check_stream("hunt", 20);
    check_eq("hunt_ok_cnt", ok_cnt, 1);
    check_eq("hunt_err_cnt", err_cnt, 0);
    $display("txn hunt_edge: ok=%0d bytes=%0d", ok_cnt, rx_data_q.size());

    // 5. backpressure and overrun
    clear_log();
    sif.i_ready = 1'b0;
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_tx();
    cycles(3);
    check_eq("bp_valid", {31'd0, sif.o_valid}, 1);
    check_eq("bp_data", {24'd0, sif.o_data}, 32'h11);
    check_eq("bp_last", {31'd0, sif.o_last}, 0);
    send_byte(8'h77, 1);
    check_eq("ovr_err_cnt", err_cnt, 1);
    check_eq("ovr_code", {30'd0, last_code}, 3);
    check_eq("ovr_data_held", {24'd0, sif.o_data}, 32'h11);
    check_eq("ovr_busy", {31'd0, busy}, 1);
    sif.i_ready = 1'b1;
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_stream("bp", 20);
    check_eq("bp_ok_cnt", ok_cnt, 1);
    $display("txn backpressure_overrun: code=%0d bytes=%0d", last_code, rx_data_q.size());

    // 6. timeout: strobes just inside the window keep the frame alive
    clear_log();
    tx_q = '{8'hA5, 8'h02, 8'h11};
    send_tx();
    cycles(TO_CLKS - 6);
    check_eq("to_alive_payload", err_cnt, 0);
    send_byte(8'h22, 1);
    cycles(TO_CLKS - 6);
    check_eq("to_alive_chk", err_cnt, 0);
    check_eq("to_busy_before", {31'd0, busy}, 1);
    wait_err("timeout", 20);
    check_eq("to_code", {30'd0, last_code}, 0);
    cycles(1);
    check_eq("to_busy_after", {31'd0, busy}, 0);
    check_eq("to_no_ok", ok_cnt, 0);
    $display("txn timeout: errs=%0d code=%0d", err_cnt, last_code);

    // 7a. reset mid-payload
    clear_log();
    tx_q = '{8'hA5, 8'h02, 8'h11};
    send_tx();
    check_eq("rst_pl_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_pl");
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // 7b. reset mid-drain, cleared asynchronously between clock edges
    sif.i_ready = 1'b0;
    tx_q = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
    send_tx();
    check_eq("rst_dr_valid_before", {31'd0, sif.o_valid}, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_dr");
    cycles(2);
    rst_n = 1'b1;
    sif.i_ready = 1'b1;
    cycles(2);
    clear_log();
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    exp_q = '{8'h11, 8'h22, 8'h33};
    send_tx();
    check_stream("post_rst", 40);
    check_eq("post_rst_ok_cnt", ok_cnt, 1);
    check_eq("post_rst_err_cnt", err_cnt, 0);
    $display("txn reset_recovery: ok=%0d bytes=%0d", ok_cnt, rx_data_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
